// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_if
// Description : Handshake bundle for serial_adder. The producer side drives
//               operands (in_valid/a/b/cin[/sub]) and out_ready; the adder
//               returns in_ready, out_valid, sum and carry.
//               Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub signal.
// Ports       : master - operand source / result sink
//               slave  - the serial adder itself
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, carry
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, carry
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, carry
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, carry
  );
`endif
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Multi-cycle adder computing {carry,sum} = a + b + cin, STEP
//               bits per clock through a registered carry, with valid/ready
//               handshakes on operands and result.
//               Optional feature macro: SERIAL_ADDER_SUB_EN - when defined,
//               bus.sub=1 at the accepting edge computes a - b (a + ~b + 1,
//               cin ignored, carry=1 means no borrow).
// Ports       : clk   - clock, rising edge
//               rst_n - synchronous active-low reset
//               bus   - serial_adder_if.slave (in_valid/in_ready/a/b/cin[/sub],
//                       out_valid/out_ready/sum/carry)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic clk,
  input  logic rst_n,
  serial_adder_if.slave bus
);

  localparam int c_BEATS = WIDTH / STEP;
  // One extra count value so the counter can pass the last beat without wrapping.
  localparam int c_CNT_W = $clog2(c_BEATS + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_BEATS - 1);

  generate
    if ((WIDTH < 2) || (STEP < 1) || (STEP > WIDTH) || ((WIDTH % STEP) != 0)) begin : g_param_check
      $error("serial_adder: WIDTH must be >= 2 and STEP must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     a_sh_q;
  logic [WIDTH-1:0]     b_sh_q;
  logic [WIDTH-1:0]     acc_q;
  logic                 cy_q;
  logic [c_CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]     sum_q;
  logic                 carry_q;
  logic                 out_valid_q;

  logic [STEP:0]        slice_d;
  logic [WIDTH-1:0]     acc_d;
  logic                 cy_d;
  logic [WIDTH-1:0]     b_load;
  logic                 cin_load;

  // Subtraction reuses the adder: invert b and force the carry-in to 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load   = bus.sub ? ~bus.b : bus.b;
  assign cin_load = bus.sub ? 1'b1   : bus.cin;
`else
  assign b_load   = bus.b;
  assign cin_load = bus.cin;
`endif

  // One STEP-bit slice of the sum plus its carry-out.
  assign slice_d = {1'b0, a_sh_q[STEP-1:0]} + {1'b0, b_sh_q[STEP-1:0]}
                 + {{STEP{1'b0}}, cy_q};
  assign cy_d    = slice_d[STEP];

  // New slice enters at the MSB so after the last beat the LSB slice
  // has travelled down to bit 0.
  generate
    if (STEP == WIDTH) begin : g_acc_full
      assign acc_d = slice_d[STEP-1:0];
    end else begin : g_acc_shift
      assign acc_d = {slice_d[STEP-1:0], acc_q[WIDTH-1:STEP]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      acc_q       <= '0;
      cy_q        <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= b_load;
            cy_q    <= cin_load;
            cnt_q   <= '0;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          a_sh_q <= a_sh_q >> STEP;
          b_sh_q <= b_sh_q >> STEP;
          acc_q  <= acc_d;
          cy_q   <= cy_d;
          cnt_q  <= cnt_q + c_CNT_W'(1);
          if (cnt_q == c_LAST) begin
            // Publish this beat's values directly; the registers above
            // only catch up on the same edge.
            sum_q       <= acc_d;
            carry_q     <= cy_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder (WIDTH=8, STEP=1).
//               Table of add vectors plus hand-written sequences for reset,
//               backpressure, abort and (with SERIAL_ADDER_SUB_EN) subtract.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  localparam int WIDTH = 8;
  localparam int STEP  = 1;
  localparam int LAT   = WIDTH / STEP;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH), .STEP(STEP)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       carry;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Call at a negedge with the DUT in IDLE; operands are presented for one edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic cin);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.in_valid = 1'b1;
  endtask

  // Returns the number of rising edges after the accepting edge until out_valid.
  task automatic wait_done(output int lat);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("in_ready_low_in_calc", {31'b0, bus.in_ready}, 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result(input logic [7:0] exp_sum, input logic exp_carry);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("in_ready_after_out_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("out_valid_low_in_idle", {31'b0, bus.out_valid}, 32'd0);
    chk("sum_held_in_idle", {24'b0, bus.sum}, {24'b0, exp_sum});
    chk("carry_held_in_idle", {31'b0, bus.carry}, {31'b0, exp_carry});
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    start_op(v.a, v.b, v.cin);
    wait_done(lat);
    chk("latency", lat, LAT);
    chk("in_ready_low_in_done", {31'b0, bus.in_ready}, 32'd0);
    chk("sum", {24'b0, bus.sum}, {24'b0, v.sum});
    chk("carry", {31'b0, bus.carry}, {31'b0, v.carry});
    release_result(v.sum, v.carry);
  endtask

  initial begin
    int lat;
    int ov_seen;
    checks = 0;
    errors = 0;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub       = 1'b0;
`endif

    // Reset for two edges
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("reset_sum", {24'b0, bus.sum}, 32'd0);
    chk("reset_carry", {31'b0, bus.carry}, 32'd0);

    // Table: back-to-back operations, each starting one cycle after out_ready
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i]);
    end

    // Backpressure: result held while out_ready=0 and in_valid=1
    start_op(8'h3C, 8'h5A, 1'b1);
    wait_done(lat);
    chk("bp_latency", lat, LAT);
    bus.a        = 8'hFF;
    bus.b        = 8'hFF;
    bus.cin      = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("bp_sum", {24'b0, bus.sum}, 32'h97);
      chk("bp_carry", {31'b0, bus.carry}, 32'd0);
    end
    bus.in_valid = 1'b0;
    release_result(8'h97, 1'b0);
    @(negedge clk);
    chk("bp_no_accept", {31'b0, bus.in_ready}, 32'd1);

    // Abort: reset lands on the 3rd CALC edge
    start_op(8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("abort_sum_cleared", {24'b0, bus.sum}, 32'd0);
    ov_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen++;
    end
    chk("abort_no_out_valid", ov_seen, 0);
    chk("abort_idle", {31'b0, bus.in_ready}, 32'd1);
    run_op('{8'h01, 8'h02, 1'b0, 8'h03, 1'b0});

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract: 0x10 - 0x20 borrows
    start_op(8'h10, 8'h20, 1'b0);
    bus.sub = 1'b1;
    wait_done(lat);
    bus.sub = 1'b0;
    chk("sub_latency", lat, LAT);
    chk("sub_sum", {24'b0, bus.sum}, 32'hF0);
    chk("sub_carry", {31'b0, bus.carry}, 32'd0);
    release_result(8'hF0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
